// File: rtl/store_buffer_ctrl.sv
// In-order store buffer: S-type address/lane formation, DEPTH-entry FIFO, single-outstanding memory drain.
// Define STORE_BUF_FWD_EN to enable combinational store-to-load forwarding.
module store_buffer_ctrl #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned IDX_W = 2
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [2:0]          in_func3,
  input  logic [31:0]         in_base,
  input  logic [11:0]         in_imm,
  input  logic [31:0]         in_data,
  input  logic                flush,
  output logic                mem_req_valid,
  input  logic                mem_req_ready,
  output logic [31:0]         mem_addr,
  output logic [31:0]         mem_wdata,
  output logic [3:0]          mem_wstrb,
  input  logic                mem_resp_valid,
  output logic                exc_valid,
  output logic                exc_misalign,
  output logic [31:0]         exc_addr,
  output logic [IDX_W:0]      count,
  input  logic [31:0]         fwd_addr,
  input  logic [3:0]          fwd_strb,
  output logic                fwd_hit,
  output logic [31:0]         fwd_data
);

  localparam int unsigned CNT_W = IDX_W + 1;

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_RESP} state_t;

  typedef struct packed {
    logic [29:0] waddr;
    logic [31:0] wdata;
    logic [3:0]  strb;
  } entry_t;

  entry_t           fifo [DEPTH];
  logic [IDX_W-1:0] head;
  logic [IDX_W-1:0] tail;
  logic [CNT_W-1:0] cnt;
  state_t           state;

  logic [31:0] eff_addr;
  logic [3:0]  lane_strb;
  logic [31:0] lane_data;
  logic        bad_f3;
  logic        misalign;
  logic        accept;
  logic        push;
  logic        pop;
  entry_t      next_head;

  // Effective address, byte lanes and fault classification of the presented store
  always_comb begin
    eff_addr  = in_base + {{20{in_imm[11]}}, in_imm};
    lane_strb = '0;
    lane_data = '0;
    misalign  = 1'b0;
    bad_f3    = 1'b0;
    case (in_func3)
      3'b000: begin
        lane_strb = 4'b0001 << eff_addr[1:0];
        lane_data = {4{in_data[7:0]}};
      end
      3'b001: begin
        lane_strb = 4'b0011 << eff_addr[1:0];
        lane_data = {2{in_data[15:0]}};
        misalign  = eff_addr[0];
      end
      3'b010: begin
        lane_strb = 4'b1111;
        lane_data = in_data;
        misalign  = |eff_addr[1:0];
      end
      default: bad_f3 = 1'b1;
    endcase
  end

  assign in_ready  = (cnt != CNT_W'(DEPTH));
  assign count     = cnt;
  assign accept    = in_valid & in_ready;
  assign push      = accept & ~bad_f3 & ~misalign & ~flush;
  assign pop       = (state == S_RESP) & mem_resp_valid;
  assign next_head = fifo[head + IDX_W'(1)];

  // Payload storage needs no reset: only entries below cnt are ever read
  always_ff @(posedge clk) begin
    if (push) begin
      fifo[tail] <= '{waddr: eff_addr[31:2], wdata: lane_data, strb: lane_strb};
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      head          <= '0;
      tail          <= '0;
      cnt           <= '0;
      state         <= S_IDLE;
      mem_req_valid <= 1'b0;
      mem_addr      <= '0;
      mem_wdata     <= '0;
      mem_wstrb     <= '0;
      exc_valid     <= 1'b0;
      exc_misalign  <= 1'b0;
      exc_addr      <= '0;
    end else begin
      exc_valid <= accept & (bad_f3 | misalign);
      if (accept & (bad_f3 | misalign)) begin
        exc_misalign <= ~bad_f3;
        exc_addr     <= eff_addr;
      end

      // Flush keeps only an entry the drain FSM has already committed to
      if (flush) begin
        if (state == S_IDLE) begin
          tail <= head;
          cnt  <= '0;
        end else if (pop) begin
          head <= head + IDX_W'(1);
          tail <= head + IDX_W'(1);
          cnt  <= '0;
        end else begin
          tail <= head + IDX_W'(1);
          cnt  <= CNT_W'(1);
        end
      end else begin
        if (push) tail <= tail + IDX_W'(1);
        if (pop)  head <= head + IDX_W'(1);
        cnt <= cnt + CNT_W'(push) - CNT_W'(pop);
      end

      case (state)
        S_IDLE: begin
          if (cnt != '0 && !flush) begin
            state         <= S_REQ;
            mem_req_valid <= 1'b1;
            mem_addr      <= {fifo[head].waddr, 2'b00};
            mem_wdata     <= fifo[head].wdata;
            mem_wstrb     <= fifo[head].strb;
          end
        end
        S_REQ: begin
          if (mem_req_ready) begin
            state         <= S_RESP;
            mem_req_valid <= 1'b0;
          end
        end
        S_RESP: begin
          if (mem_resp_valid) begin
            if (cnt > CNT_W'(1) && !flush) begin
              state         <= S_REQ;
              mem_req_valid <= 1'b1;
              mem_addr      <= {next_head.waddr, 2'b00};
              mem_wdata     <= next_head.wdata;
              mem_wstrb     <= next_head.strb;
            end else begin
              state <= S_IDLE;
            end
          end
        end
        default: begin
          state         <= S_IDLE;
          mem_req_valid <= 1'b0;
        end
      endcase
    end
  end

`ifdef STORE_BUF_FWD_EN
  logic [IDX_W-1:0] fwd_idx;
  logic             unused_fwd_lsb;
  assign unused_fwd_lsb = ^fwd_addr[1:0];

  // Scan oldest to youngest so the youngest covering entry wins
  always_comb begin
    fwd_hit  = 1'b0;
    fwd_data = '0;
    fwd_idx  = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      fwd_idx = head + IDX_W'(i);
      if (CNT_W'(i) < cnt && fifo[fwd_idx].waddr == fwd_addr[31:2] &&
          (fifo[fwd_idx].strb & fwd_strb) == fwd_strb) begin
        fwd_hit  = 1'b1;
        fwd_data = fifo[fwd_idx].wdata;
      end
    end
  end
`else
  logic unused_fwd;
  assign unused_fwd = ^{fwd_addr, fwd_strb};
  assign fwd_hit    = 1'b0;
  assign fwd_data   = '0;
`endif

endmodule
